alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 16-op ALU; same opcode set, plus a full-width product and backpressure.
- A/B/S operands are accepted on a valid/ready input port.
- The result (Y, high product YH, flags C/V/Z) is presented on a valid/ready output port.
- Single-cycle ops complete in 1 cycle. MUL runs iteratively for DWIDTH cycles.
- Sits between the instruction sequencer and the register file writeback.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_alu_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcode map, controller state encoding
// and the packed {C,V,Z} flag vector.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_INCA = 4'd1;
    localparam logic [3:0] OP_INCB = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_SL   = 4'd5;
    localparam logic [3:0] OP_SR   = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_DECA = 4'd8;
    localparam logic [3:0] OP_DECB = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_CPLA = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_CPLB = 4'd15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, DWIDTH cycles.
// o_done pulses combinationally on the final step with the finished product on o_product.
module alu_mul_seq #(
    parameter int DWIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_clr_n,
    input  logic                  i_start,
    input  logic [DWIDTH-1:0]     i_a,
    input  logic [DWIDTH-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DWIDTH-1:0]   o_product
);

    localparam int CW = $clog2(DWIDTH);

    logic                r_run;
    logic [CW-1:0]       r_cnt;
    logic [2*DWIDTH-1:0] r_mcand;
    logic [DWIDTH-1:0]   r_mplier;
    logic [2*DWIDTH-1:0] r_acc;

    logic [2*DWIDTH-1:0] w_acc_next;
    logic                w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = r_run && (r_cnt == CW'(DWIDTH - 1));

    // The last step's sum is handed out directly so the caller can register it on the same edge.
    assign o_done    = w_last;
    assign o_product = w_acc_next;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{DWIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*DWIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DWIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 16-op ALU: single-cycle ops register in one cycle, MUL runs on the
// iterative multiplier; results are held on a valid/ready output port.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int OPWIDTH = 4,
    parameter int SHW     = $clog2(DWIDTH)
) (
    input  logic               CLK,
    input  logic               CLR_N,
    input  logic [DWIDTH-1:0]  A,
    input  logic [DWIDTH-1:0]  B,
    input  logic [OPWIDTH-1:0] S,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [DWIDTH-1:0]  Y,
    output logic [DWIDTH-1:0]  YH,
    output logic               C,
    output logic               V,
    output logic               Z,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               BUSY
);

    localparam int M = DWIDTH - 1;

    logic [0:0]          r_state;
    logic [DWIDTH-1:0]   r_y;
    logic [DWIDTH-1:0]   r_yh;
    flags_t              r_flags;
    logic                r_out_valid;

    logic [3:0]          w_op;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_start_mul;
    logic [DWIDTH-1:0]   w_opa;
    logic [DWIDTH-1:0]   w_opb;
    logic                w_sub;
    logic [DWIDTH:0]     w_sum;
    logic                w_arith_v;
    logic [SHW-1:0]      w_sh;
    logic [DWIDTH:0]     w_shl;
    logic [DWIDTH:0]     w_shr;
    logic [DWIDTH-1:0]   w_y;
    logic                w_c;
    logic                w_v;
    logic                w_mul_done;
    logic [2*DWIDTH-1:0] w_product;

    // Opcodes wider than the 16-op map decode to CLR whenever any extra bit is set.
    generate
        if (OPWIDTH > 4) begin : g_wide_op
            assign w_op = (|S[OPWIDTH-1:4]) ? OP_CLR : S[3:0];
        end else begin : g_op
            assign w_op = S[3:0];
        end
    endgenerate

    assign w_in_ready  = (r_state == ST_IDLE) && (!r_out_valid || OUT_READY);
    assign w_accept    = IN_VALID && w_in_ready;
    assign w_start_mul = w_accept && (w_op == OP_MUL);

    always_comb begin
        w_opa = A;
        w_opb = B;
        w_sub = 1'b0;
        case (w_op)
            OP_INCA: w_opb = DWIDTH'(1);
            OP_INCB: begin w_opa = B; w_opb = DWIDTH'(1); end
            OP_SUB, OP_CMP: w_sub = 1'b1;
            OP_DECA: begin w_opb = DWIDTH'(1); w_sub = 1'b1; end
            OP_DECB: begin w_opa = B; w_opb = DWIDTH'(1); w_sub = 1'b1; end
            default: ;
        endcase
    end

    // Top bit of the widened difference is the borrow (A<B unsigned).
    assign w_sum = w_sub ? ({1'b0, w_opa} - {1'b0, w_opb})
                         : ({1'b0, w_opa} + {1'b0, w_opb});
    assign w_arith_v = w_sub ? ((w_opa[M] != w_opb[M]) && (w_sum[M] != w_opa[M]))
                             : ((w_opa[M] == w_opb[M]) && (w_sum[M] != w_opa[M]));

    // One guard bit on each shifter catches the last bit shifted out.
    assign w_sh  = B[SHW-1:0];
    assign w_shl = {1'b0, A} << w_sh;
    assign w_shr = {A, 1'b0} >> w_sh;

    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (w_op)
            OP_ADD, OP_INCA, OP_INCB, OP_SUB, OP_DECA, OP_DECB: begin
                w_y = w_sum[DWIDTH-1:0];
                w_c = w_sum[DWIDTH];
                w_v = w_arith_v;
            end
            OP_CMP: begin
                w_y = A;
                w_c = w_sum[DWIDTH];
                w_v = w_arith_v;
            end
            OP_SL:   {w_c, w_y} = w_shl;
            OP_SR:   {w_y, w_c} = w_shr;
            OP_CPLA: w_y = ~A;
            OP_CPLB: w_y = ~B;
            OP_AND:  w_y = A & B;
            OP_OR:   w_y = A | B;
            OP_XOR:  w_y = A ^ B;
            default: ;
        endcase
    end

    alu_mul_seq #(
        .DWIDTH(DWIDTH)
    ) u_mul (
        .i_clk     (CLK),
        .i_clr_n   (CLR_N),
        .i_start   (w_start_mul),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            r_state     <= ST_IDLE;
            r_y         <= '0;
            r_yh        <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // A consumed result drops valid unless a new one is loaded below on the same edge.
            if (OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_start_mul) begin
                r_y         <= w_y;
                r_yh        <= '0;
                r_flags     <= {w_c, w_v, ~|w_y};
                r_out_valid <= 1'b1;
            end
            if (w_start_mul) begin
                r_state <= ST_MUL;
            end
            if ((r_state == ST_MUL) && w_mul_done) begin
                r_y         <= w_product[DWIDTH-1:0];
                r_yh        <= w_product[2*DWIDTH-1:DWIDTH];
                r_flags     <= {1'b0, |w_product[2*DWIDTH-1:DWIDTH], ~|w_product};
                r_out_valid <= 1'b1;
                r_state     <= ST_IDLE;
            end
        end
    end

    assign IN_READY  = w_in_ready;
    assign Y         = r_y;
    assign YH        = r_yh;
    assign C         = r_flags.c;
    assign V         = r_flags.v;
    assign Z         = r_flags.z;
    assign OUT_VALID = r_out_valid;
    assign BUSY      = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes reference results at accept,
// a negedge monitor checks handshake timing and pops/compares presented results.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          CLR_N;
    logic [W-1:0]  A, B;
    logic [3:0]    S;
    logic          IN_VALID;
    logic          IN_READY;
    logic [W-1:0]  Y, YH;
    logic          C, V, Z;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          BUSY;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] yh;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mul_acc = 0;
    bit   mul_pend = 1'b0;
    int   rdy_mode = 2;
    int   txn = 0;
    bit   mon_ev, mon_eb, mon_er;

    alu_pipe dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .A         (A),
        .B         (B),
        .S         (S),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .Y         (Y),
        .YH        (YH),
        .C         (C),
        .V         (V),
        .Z         (Z),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference arithmetic on plain integers: signed overflow judged by range.
    function automatic void arith(input int x, input int y, input bit sub,
                                  output logic [W-1:0] res, output logic c, output logic v);
        int sx, sy, s, r;
        sx = (x >= 32768) ? x - 65536 : x;
        sy = (y >= 32768) ? y - 65536 : y;
        if (sub) begin
            s = x - y; r = sx - sy; c = (x < y);
        end else begin
            s = x + y; r = sx + sy; c = (s > 65535);
        end
        res = s[W-1:0];
        v = (r > 32767) || (r < -32768);
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a16, input logic [W-1:0] b16);
        exp_t e;
        int a, b, n, t;
        longint p;
        a = int'(a16); b = int'(b16); n = b % 16;
        e.y = '0; e.yh = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0; e.lat = 1;
        case (op)
            OP_ADD:  arith(a, b, 1'b0, e.y, e.c, e.v);
            OP_INCA: arith(a, 1, 1'b0, e.y, e.c, e.v);
            OP_INCB: arith(b, 1, 1'b0, e.y, e.c, e.v);
            OP_SUB:  arith(a, b, 1'b1, e.y, e.c, e.v);
            OP_CMP:  begin arith(a, b, 1'b1, e.y, e.c, e.v); e.y = a16; end
            OP_DECA: arith(a, 1, 1'b1, e.y, e.c, e.v);
            OP_DECB: arith(b, 1, 1'b1, e.y, e.c, e.v);
            OP_SL: begin
                t = a << n; e.y = t[W-1:0];
                e.c = (n != 0) && (((a >> (16 - n)) & 1) != 0);
            end
            OP_SR: begin
                t = a >> n; e.y = t[W-1:0];
                e.c = (n != 0) && (((a >> (n - 1)) & 1) != 0);
            end
            OP_MUL: begin
                p = longint'(a) * longint'(b);
                e.y = p[15:0]; e.yh = p[31:16]; e.v = (e.yh != 0); e.lat = 17;
            end
            OP_CPLA: e.y = ~a16;
            OP_CPLB: e.y = ~b16;
            OP_AND:  e.y = a16 & b16;
            OP_OR:   e.y = a16 | b16;
            OP_XOR:  e.y = a16 ^ b16;
            default: ;
        endcase
        e.z = (e.y == 0) && (e.yh == 0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        exp_t e;
        bit done;
        done = 1'b0; waited = 0;
        A = a; B = b; S = op; IN_VALID = 1'b1;
        e = model(op, a, b);
        while (!done) begin
            @(negedge CLK);
            if (IN_READY) begin
                e.acc = cyc;
                q.push_back(e);
                if (op == OP_MUL) begin mul_pend = 1'b1; mul_acc = cyc; end
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: op=%0d still not accepted after %0d cycles, required acceptance", op, waited);
                    done = 1'b1;
                end
            end
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0; A = W'($urandom); B = W'($urandom); S = 4'($urandom);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({Y, YH, C, V, Z, OUT_VALID, BUSY} !== '0) begin
            errors++;
            $display("FAIL %s: got Y=%h YH=%h C=%b V=%b Z=%b OUT_VALID=%b BUSY=%b, required all 0",
                     name, Y, YH, C, V, Z, OUT_VALID, BUSY);
        end
    endtask

    task automatic check_int(input string name, input bit ok, input int got);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required condition not met", name, got);
        end
    endtask

    task automatic drain();
        int n;
        @(posedge CLK); #2 rdy_mode = 2;
        n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge CLK); n++; end
        #1;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    // OUT_READY driver: random, held low, or held high.
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            case (rdy_mode)
                0: OUT_READY = ($urandom_range(0, 3) != 0);
                1: OUT_READY = 1'b0;
                default: OUT_READY = 1'b1;
            endcase
        end
    end

    // Monitor: every cycle compares valid/ready/busy against the model, and the presented result.
    always @(negedge CLK) begin
        if (CLR_N === 1'b1) begin
            mon_ev = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
            mon_eb = mul_pend && (cyc > mul_acc) && (cyc <= mul_acc + 16);
            mon_er = !mon_eb && (!mon_ev || OUT_READY);
            checks++;
            if (OUT_VALID !== mon_ev) begin
                errors++;
                $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, OUT_VALID, mon_ev);
            end
            checks++;
            if (BUSY !== mon_eb) begin
                errors++;
                $display("FAIL busy cyc=%0d: got %b, required %b", cyc, BUSY, mon_eb);
            end
            checks++;
            if (IN_READY !== mon_er) begin
                errors++;
                $display("FAIL in_ready cyc=%0d: got %b, required %b", cyc, IN_READY, mon_er);
            end
            if (mon_ev) begin
                checks++;
                if (Y !== q[0].y || YH !== q[0].yh || C !== q[0].c || V !== q[0].v || Z !== q[0].z) begin
                    errors++;
                    $display("FAIL result cyc=%0d: got Y=%h YH=%h C=%b V=%b Z=%b, required Y=%h YH=%h C=%b V=%b Z=%b",
                             cyc, Y, YH, C, V, Z, q[0].y, q[0].yh, q[0].c, q[0].v, q[0].z);
                end
                if (OUT_READY) begin
                    txn++;
                    $display("txn %0d cyc=%0d Y=%h YH=%h C=%b V=%b Z=%b", txn, cyc, Y, YH, C, V, Z);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w1, w2, w3;
        logic [3:0] op;
        CLR_N = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; S = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset_state");
        @(posedge CLK); #1 CLR_N = 1'b1;

        // Directed cases
        send(OP_ADD,  16'h7FFF, 16'h0001, w);
        send(OP_SUB,  16'h0003, 16'h0005, w);
        send(OP_CMP,  16'h0003, 16'h0005, w);
        send(OP_MUL,  16'h1234, 16'h0100, w);
        send(OP_SL,   16'h8001, 16'h0001, w);
        send(OP_SR,   16'hA5C3, 16'h0000, w);
        send(OP_INCA, 16'hFFFF, 16'h0000, w);
        send(OP_DECB, 16'h1234, 16'h0000, w);
        send(OP_CLR,  16'hFFFF, 16'hFFFF, w);
        drain();

        // Backpressure: first ADD held, second accepted only in the single OUT_READY cycle
        @(posedge CLK); #2 rdy_mode = 1;
        @(posedge CLK); #1;
        fork
            begin
                send(OP_ADD, 16'h0001, 16'h0002, w1);
                send(OP_ADD, 16'h0010, 16'h0020, w2);
                send(OP_ADD, 16'h0100, 16'h0200, w3);
            end
            begin
                repeat (6) @(posedge CLK);
                #2 rdy_mode = 2;
                @(posedge CLK); #2 rdy_mode = 1;
                repeat (4) @(posedge CLK);
                #2 rdy_mode = 2;
            end
        join
        check_int("bp_first_immediate", w1 == 0, w1);
        check_int("bp_second_waited", w2 > 0, w2);
        check_int("bp_third_waited", w3 > 0, w3);
        drain();

        // Randomized traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            send(op, rnd_val(), rnd_val(), w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
            #0;
        end
        drain();

        // Reset in the middle of a multiply aborts it
        send(OP_MUL, 16'hFFFF, 16'hFFFF, w);
        repeat (4) @(posedge CLK);
        #1 CLR_N = 1'b0;
        @(posedge CLK); #1;
        q.delete(); mul_pend = 1'b0;
        @(negedge CLK);
        check_zero("reset_mid_mul");
        @(posedge CLK); #1 CLR_N = 1'b1;
        send(OP_ADD, 16'h1111, 16'h2222, w);
        check_int("accept_after_reset", w == 0, w);
        drain();
        repeat (20) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
